// File: rtl/data_mem_pipe_if.sv
// M-stage request/response bundle between pipeline control (master) and the data memory (slave).
interface data_mem_pipe_if;
   logic        M_valid;
   logic [5:0]  M_op;
   logic [31:0] M_valE;
   logic [31:0] M_valA;
   logic [31:0] m_valM;
   logic        m_stall;
   logic        m_done;
   logic        m_adel;
   logic        m_ades;

   modport master (
      output M_valid, M_op, M_valE, M_valA,
      input  m_valM, m_stall, m_done, m_adel, m_ades
   );

   modport slave (
      input  M_valid, M_op, M_valE, M_valA,
      output m_valM, m_stall, m_done, m_adel, m_ades
   );
endinterface

// File: rtl/data_mem_pipe.sv
// M-stage data memory: byte/half/word loads and stores, byte-lane writes, misaligned-address flags.
// Each access takes LATENCY+1 cycles; m_stall holds the pipeline until the one-cycle m_done pulse.
module data_mem_pipe #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input logic            clk,
   input logic            reset,
   data_mem_pipe_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   localparam logic [5:0] ILB  = 6'h20;
   localparam logic [5:0] ILH  = 6'h21;
   localparam logic [5:0] ILW  = 6'h23;
   localparam logic [5:0] ILBU = 6'h24;
   localparam logic [5:0] ILHU = 6'h25;
   localparam logic [5:0] ISB  = 6'h28;
   localparam logic [5:0] ISH  = 6'h29;
   localparam logic [5:0] ISW  = 6'h2B;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic isLoadOp(input logic [5:0] op);
      return (op == ILB) || (op == ILH) || (op == ILW) || (op == ILBU) || (op == ILHU);
   endfunction

   function automatic logic isStoreOp(input logic [5:0] op);
      return (op == ISB) || (op == ISH) || (op == ISW);
   endfunction

   state_t          state, nextState;
   logic [CW-1:0]   cnt;
   logic [5:0]      opReg;
   logic [AW+1:0]   addrReg;
   logic [31:0]     dataReg;
   logic [31:0]     rdata;
   logic [31:0]     mem [DEPTH_WORDS];

   logic            isLoad, isStore, aligned, req, commit;
   logic [AW-1:0]   wordIdx;
   logic [3:0]      wrEn;
   logic [31:0]     wrData;
   logic [7:0]      loadByte;
   logic [15:0]     loadHalf;
   logic [31:0]     loadResult;

   always_comb begin
      isLoad  = isLoadOp(bus.M_op);
      isStore = isStoreOp(bus.M_op);
      case (bus.M_op)
         ILH, ILHU, ISH: aligned = ~bus.M_valE[0];
         ILW, ISW:       aligned = (bus.M_valE[1:0] == 2'b00);
         default:        aligned = 1'b1;
      endcase
      req = bus.M_valid && (isLoad || isStore) && aligned;
   end

   assign commit  = (state == BUSY) && (cnt == '0);
   assign wordIdx = addrReg[AW+1:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (req) nextState = BUSY;
         BUSY:    if (cnt == '0) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         opReg   <= '0;
         addrReg <= '0;
         dataReg <= '0;
         rdata   <= '0;
      end else begin
         if (state == IDLE && req) begin
            cnt     <= CNT_INIT;
            opReg   <= bus.M_op;
            addrReg <= bus.M_valE[AW+1:0];
            dataReg <= bus.M_valA;
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (commit && isLoadOp(opReg)) rdata <= mem[wordIdx];
      end
   end

   // Store data is replicated across lanes so only the enables need to follow the address.
   always_comb begin
      wrEn   = 4'b0000;
      wrData = dataReg;
      case (opReg)
         ISB: begin
            wrEn   = 4'b0001 << addrReg[1:0];
            wrData = {4{dataReg[7:0]}};
         end
         ISH: begin
            wrEn   = addrReg[1] ? 4'b1100 : 4'b0011;
            wrData = {2{dataReg[15:0]}};
         end
         ISW:     wrEn = 4'b1111;
         default: wrEn = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && isStoreOp(opReg)) begin
         for (int i = 0; i < 4; i++)
            if (wrEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
   end

   always_comb begin
      case (addrReg[1:0])
         2'd0:    loadByte = rdata[7:0];
         2'd1:    loadByte = rdata[15:8];
         2'd2:    loadByte = rdata[23:16];
         default: loadByte = rdata[31:24];
      endcase
      loadHalf = addrReg[1] ? rdata[31:16] : rdata[15:0];
      case (opReg)
         ILB:     loadResult = {{24{loadByte[7]}}, loadByte};
         ILBU:    loadResult = {24'h0, loadByte};
         ILH:     loadResult = {{16{loadHalf[15]}}, loadHalf};
         ILHU:    loadResult = {16'h0, loadHalf};
         ILW:     loadResult = rdata;
         default: loadResult = 32'h0;
      endcase
   end

   // Address-error flags exist only in IDLE, where a misaligned op is rejected without stalling.
   always_comb begin
      bus.m_valM  = 32'h0;
      bus.m_stall = 1'b0;
      bus.m_done  = 1'b0;
      bus.m_adel  = 1'b0;
      bus.m_ades  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               bus.m_stall = 1'b1;
            end else if (bus.M_valid) begin
               bus.m_adel = isLoad;
               bus.m_ades = isStore;
            end
         end
         BUSY: bus.m_stall = 1'b1;
         DONE: begin
            bus.m_done = 1'b1;
            bus.m_valM = loadResult;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe (LATENCY=2, DEPTH_WORDS=256) with hand-computed expectations.
module tb_data_mem_pipe;
   localparam logic [5:0] ILB  = 6'h20;
   localparam logic [5:0] ILH  = 6'h21;
   localparam logic [5:0] ILW  = 6'h23;
   localparam logic [5:0] ILBU = 6'h24;
   localparam logic [5:0] ILHU = 6'h25;
   localparam logic [5:0] ISB  = 6'h28;
   localparam logic [5:0] ISH  = 6'h29;
   localparam logic [5:0] ISW  = 6'h2B;

   logic clk;
   logic reset;
   int   nChecks = 0;
   int   nFails  = 0;

   data_mem_pipe_if bus();

   data_mem_pipe #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkEq({tag, "/valM"},  bus.m_valM, 32'h0);
      checkEq({tag, "/stall"}, 32'(bus.m_stall), 32'h0);
      checkEq({tag, "/done"},  32'(bus.m_done), 32'h0);
      checkEq({tag, "/adel"},  32'(bus.m_adel), 32'h0);
      checkEq({tag, "/ades"},  32'(bus.m_ades), 32'h0);
   endtask

   // Issue one aligned access and follow it to its m_done pulse (bounded to 10 cycles).
   task automatic doAccess(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble, input logic [31:0] expVal);
      int stallCnt = 0;
      int doneAt   = -1;
      int flagCnt  = 0;
      logic [31:0] res = 32'h0;
      @(negedge clk);
      bus.M_valid = 1'b1;
      bus.M_op    = op;
      bus.M_valE  = addr;
      bus.M_valA  = data;
      for (int i = 0; i < 10 && doneAt < 0; i++) begin
         #2;
         if (bus.m_stall) stallCnt++;
         if (bus.m_adel || bus.m_ades) flagCnt++;
         if (bus.m_done) begin
            doneAt      = i;
            res         = bus.m_valM;
            bus.M_valid = 1'b0;
         end
         if (scramble && i == 1) begin
            bus.M_op   = ISW;
            bus.M_valE = 32'h20;
            bus.M_valA = 32'hCAFEF00D;
         end
         if (doneAt < 0) @(negedge clk);
      end
      bus.M_valid = 1'b0;
      checkEq({tag, "/stallCycles"}, 32'(stallCnt), 32'd3);
      checkEq({tag, "/doneCycle"},   32'(doneAt), 32'd3);
      checkEq({tag, "/errFlags"},    32'(flagCnt), 32'd0);
      checkEq({tag, "/valM"},        res, expVal);
      @(negedge clk);
      #2;
      checkEq({tag, "/donePulse"}, 32'(bus.m_done), 32'h0);
   endtask

   // Present a request that must not start an access; watch a few cycles for stray stall/done.
   task automatic doNoAccess(input string tag, input logic valid, input logic [5:0] op,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic expAdel, input logic expAdes);
      int busyCnt = 0;
      @(negedge clk);
      bus.M_valid = valid;
      bus.M_op    = op;
      bus.M_valE  = addr;
      bus.M_valA  = data;
      #2;
      checkEq({tag, "/adel"},  32'(bus.m_adel), 32'(expAdel));
      checkEq({tag, "/ades"},  32'(bus.m_ades), 32'(expAdes));
      checkEq({tag, "/stall"}, 32'(bus.m_stall), 32'h0);
      checkEq({tag, "/valM"},  bus.m_valM, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         if (bus.m_done || bus.m_stall) busyCnt++;
      end
      checkEq({tag, "/noAccess"}, 32'(busyCnt), 32'd0);
      bus.M_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      bus.M_valid = 1'b0;
      bus.M_op    = 6'h00;
      bus.M_valE  = 32'h0;
      bus.M_valA  = 32'h0;
      repeat (2) @(negedge clk);
      #2;
      checkIdleOutputs("reset");
      @(negedge clk);
      reset = 1'b0;
      #2;
      checkIdleOutputs("postReset");

      doAccess("sw10",   ISW,  32'h10, 32'h11223344, 1'b0, 32'h0);
      doAccess("lw10a",  ILW,  32'h10, 32'h0,        1'b0, 32'h11223344);

      doAccess("sb13",   ISB,  32'h13, 32'h000000AA, 1'b0, 32'h0);
      doAccess("lw10b",  ILW,  32'h10, 32'h0,        1'b0, 32'hAA223344);
      doAccess("lb13",   ILB,  32'h13, 32'h0,        1'b0, 32'hFFFFFFAA);
      doAccess("lbu13",  ILBU, 32'h13, 32'h0,        1'b0, 32'h000000AA);

      doAccess("sh12",   ISH,  32'h12, 32'h00008001, 1'b0, 32'h0);
      doAccess("lh12",   ILH,  32'h12, 32'h0,        1'b0, 32'hFFFF8001);
      doAccess("lhu12",  ILHU, 32'h12, 32'h0,        1'b0, 32'h00008001);
      doAccess("lw10c",  ILW,  32'h10, 32'h0,        1'b0, 32'h80013344);

      doNoAccess("lwMis", 1'b1, ILW, 32'h12, 32'h0,    1'b1, 1'b0);
      doNoAccess("shMis", 1'b1, ISH, 32'h11, 32'hFFFF, 1'b0, 1'b1);
      doAccess("lw10d",  ILW,  32'h10, 32'h0,        1'b0, 32'h80013344);

      doAccess("sw20z",  ISW,  32'h20, 32'h0,        1'b0, 32'h0);
      @(negedge clk);
      bus.M_valid = 1'b1;
      bus.M_op    = ISW;
      bus.M_valE  = 32'h20;
      bus.M_valA  = 32'hDEADBEEF;
      @(negedge clk);
      #2;
      checkEq("midRst/busyStall", 32'(bus.m_stall), 32'h1);
      reset       = 1'b1;
      bus.M_valid = 1'b0;
      #1;
      checkIdleOutputs("midRst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      doAccess("lw20",   ILW,  32'h20,  32'h0,       1'b0, 32'h00000000);
      doAccess("lw410",  ILW,  32'h410, 32'h0,       1'b0, 32'h80013344);

      doNoAccess("nonMem",  1'b1, 6'h00, 32'h10, 32'h0, 1'b0, 1'b0);
      doNoAccess("invalid", 1'b0, ILW,   32'h10, 32'h0, 1'b0, 1'b0);

      doAccess("lwScr",  ILW,  32'h10, 32'h0,        1'b1, 32'h80013344);
      doAccess("lw20b",  ILW,  32'h20, 32'h0,        1'b0, 32'h00000000);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
